// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants and helpers for the write-back stage and register file.
package wb_regfile_pkg;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;
    localparam int RN_W  = 5;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [RN_W-1:0] regnum_t;

    // A write only lands when it is requested and does not target the hard-wired zero register.
    function automatic logic is_commit(input logic regwrite, input regnum_t wn);
        return regwrite && (wn != {RN_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_regfile_regfile_32x32.sv
// 31-entry general register file with hard-wired zero r0, one write port and two
// combinational read ports; contents clear asynchronously on rst.
module regfile_32x32
    import wb_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RN_W-1:0] wn,
    input  logic [XLEN-1:0] wd,
    input  logic [RN_W-1:0] rn1,
    input  logic [RN_W-1:0] rn2,
    output logic [XLEN-1:0] qa,
    output logic [XLEN-1:0] qb
);

    logic [XLEN-1:0] regs_r [1:NREGS-1];

    // Storage update: async clear, then single write port guarded against r0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (wn != {RN_W{1'b0}})) begin
            regs_r[wn] <= wd;
        end
    end

    // Read port A: r0 and reset both read as zero.
    always_comb begin
        qa = {XLEN{1'b0}};
        if (rst || (rn1 == {RN_W{1'b0}})) begin
            qa = {XLEN{1'b0}};
        end else begin
            qa = regs_r[rn1];
        end
    end

    // Read port B: r0 and reset both read as zero.
    always_comb begin
        qb = {XLEN{1'b0}};
        if (rst || (rn2 == {RN_W{1'b0}})) begin
            qb = {XLEN{1'b0}};
        end else begin
            qb = regs_r[rn2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, register file, commit counter and optional WB->ID
// write-through bypass enabled by defining WB_BYPASS_EN.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int WCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [RN_W-1:0]   wn,
    input  logic [XLEN-1:0]   rd,
    input  logic [XLEN-1:0]   Muxout,
    input  logic [RN_W-1:0]   rn1,
    input  logic [RN_W-1:0]   rn2,
    output logic [XLEN-1:0]   qa,
    output logic [XLEN-1:0]   qb,
    output logic [XLEN-1:0]   wb_data,
    output logic [WCNT_W-1:0] wb_cnt
);

    logic [XLEN-1:0]   wb_data_s;
    logic [XLEN-1:0]   rf_qa_s;
    logic [XLEN-1:0]   rf_qb_s;
    logic              commit_s;
    logic [WCNT_W-1:0] wb_cnt_r;

    assign wb_data_s = MemtoReg ? rd : Muxout;
    assign commit_s  = is_commit(RegWrite, wn) && !rst;
    assign wb_data   = wb_data_s;
    assign wb_cnt    = wb_cnt_r;

    regfile_32x32 u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (RegWrite),
        .wn  (wn),
        .wd  (wb_data_s),
        .rn1 (rn1),
        .rn2 (rn2),
        .qa  (rf_qa_s),
        .qb  (rf_qb_s)
    );

    // Commit counter; wraps freely at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cnt_r <= {WCNT_W{1'b0}};
        end else if (commit_s) begin
            wb_cnt_r <= wb_cnt_r + WCNT_W'(1);
        end else begin
            wb_cnt_r <= wb_cnt_r;
        end
    end

`ifdef WB_BYPASS_EN
    // Write-through: a same-cycle commit to the read register is forwarded to the reader.
    always_comb begin
        qa = rf_qa_s;
        if (commit_s && (wn == rn1)) begin
            qa = wb_data_s;
        end else begin
            qa = rf_qa_s;
        end
    end

    // Same forwarding for port B.
    always_comb begin
        qb = rf_qb_s;
        if (commit_s && (wn == rn2)) begin
            qb = wb_data_s;
        end else begin
            qb = rf_qb_s;
        end
    end
`else
    assign qa = rf_qa_s;
    assign qb = rf_qb_s;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (4-bit commit counter to exercise wrap).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  wn;
    logic [31:0] rd;
    logic [31:0] Muxout;
    logic [4:0]  rn1;
    logic [4:0]  rn2;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] wb_data;
    logic [3:0]  wb_cnt;

    int vectors;
    int miscompares;
    logic [3:0]  exp_cnt;
    logic [31:0] exp_byp;

    wb_regfile #(.WCNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .wn       (wn),
        .rd       (rd),
        .Muxout   (Muxout),
        .rn1      (rn1),
        .rn2      (rn2),
        .qa       (qa),
        .qb       (qb),
        .wb_data  (wb_data),
        .wb_cnt   (wb_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        wn       = 5'd0;
        rd       = 32'h0;
        Muxout   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        for (int i = 0; i < 32; i++) begin
            rn1 = i[4:0];
            rn2 = i[4:0];
            #1;
            vectors++;
            if (qa !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_qa r%0d: got %h want 00000000", i, qa);
            end
            vectors++;
            if (qb !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_qb r%0d: got %h want 00000000", i, qb);
            end
        end
        vectors++;
        if (wb_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", wb_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_mem_select();
        @(negedge clk);
        MemtoReg = 1'b1; RegWrite = 1'b1; wn = 5'd5;
        rd = 32'hDEADBEEF; Muxout = 32'h12345678; rn1 = 5'd5; rn2 = 5'd5;
        #1;
        vectors++;
        if (wb_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wbdata_mem: got %h want deadbeef", wb_data);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++;
        if (qa !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL r5_mem: got %h want deadbeef", qa);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_after_mem: got %0d want %0d", wb_cnt, exp_cnt);
        end
        @(negedge clk);
        MemtoReg = 1'b0;
        #1;
        vectors++;
        if (wb_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wbdata_alu: got %h want 12345678", wb_data);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++;
        if (qa !== 32'h12345678) begin
            miscompares++;
            $display("FAIL r5_alu: got %h want 12345678", qa);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_after_alu: got %0d want %0d", wb_cnt, exp_cnt);
        end
        vectors++;
        if (qb !== 32'h12345678) begin
            miscompares++;
            $display("FAIL same_port_qb: got %h want 12345678", qb);
        end
    endtask

    task automatic test_r0_and_nowrite();
        @(negedge clk);
        MemtoReg = 1'b0; RegWrite = 1'b1; wn = 5'd0; Muxout = 32'hFFFFFFFF;
        rn1 = 5'd0; rn2 = 5'd5;
        tick();
        vectors++;
        if (qa !== 32'h0) begin
            miscompares++;
            $display("FAIL r0_write: got %h want 00000000", qa);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_r0: got %0d want %0d", wb_cnt, exp_cnt);
        end
        @(negedge clk);
        RegWrite = 1'b0; MemtoReg = 1'b1; wn = 5'd5; rd = 32'hCAFEF00D; Muxout = 32'h55555555;
        tick();
        vectors++;
        if (qb !== 32'h12345678) begin
            miscompares++;
            $display("FAIL nowrite_r5: got %h want 12345678", qb);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_nowrite: got %0d want %0d", wb_cnt, exp_cnt);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        MemtoReg = 1'b0; RegWrite = 1'b1; wn = 5'd7; Muxout = 32'h11;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        @(negedge clk);
        Muxout = 32'h22; rn1 = 5'd7; rn2 = 5'd5;
`ifdef WB_BYPASS_EN
        exp_byp = 32'h22;
`else
        exp_byp = 32'h11;
`endif
        #1;
        vectors++;
        if (qa !== exp_byp) begin
            miscompares++;
            $display("FAIL bypass_pre_edge: got %h want %h", qa, exp_byp);
        end
        vectors++;
        if (qb !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_other_port: got %h want 12345678", qb);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++;
        if (qa !== 32'h22) begin
            miscompares++;
            $display("FAIL bypass_post_edge: got %h want 00000022", qa);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_bypass: got %0d want %0d", wb_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 4'd0;
        rn1 = 5'd1; rn2 = 5'd1;
        RegWrite = 1'b1; wn = 5'd1;
        for (int i = 1; i <= 16; i++) begin
            Muxout = 32'h100 + i;
            tick();
            @(negedge clk);
            if (i == 15) begin
                vectors++;
                if (wb_cnt !== 4'd15) begin
                    miscompares++;
                    $display("FAIL cnt_allones: got %0d want 15", wb_cnt);
                end
            end
        end
        vectors++;
        if (wb_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %0d want 0", wb_cnt);
        end
        vectors++;
        if (qa !== 32'h110) begin
            miscompares++;
            $display("FAIL wrap_r1: got %h want 00000110", qa);
        end
    endtask

    task automatic test_reset_midcycle();
        RegWrite = 1'b1; wn = 5'd1; MemtoReg = 1'b0; Muxout = 32'hAAAA5555;
        rn1 = 5'd1; rn2 = 5'd1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (qa !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_qa: got %h want 00000000", qa);
        end
        vectors++;
        if (wb_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL midrst_cnt: got %0d want 0", wb_cnt);
        end
        vectors++;
        if (wb_data !== 32'hAAAA5555) begin
            miscompares++;
            $display("FAIL midrst_wbdata: got %h want aaaa5555", wb_data);
        end
        tick();
        vectors++;
        if ((qb !== 32'h0) || (wb_cnt !== 4'd0)) begin
            miscompares++;
            $display("FAIL midrst_edge: qb %h cnt %0d want 0 and 0", qb, wb_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (qa !== 32'h0) begin
            miscompares++;
            $display("FAIL post_rst_r1: got %h want 00000000", qa);
        end
        tick();
        vectors++;
        if (qa !== 32'hAAAA5555) begin
            miscompares++;
            $display("FAIL first_commit: got %h want aaaa5555", qa);
        end
        vectors++;
        if (wb_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL first_commit_cnt: got %0d want 1", wb_cnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        rn1 = 5'd0;
        rn2 = 5'd0;
        exp_cnt = 4'd0;
        exp_byp = 32'h0;
        idle_inputs();
        test_reset();
        test_mem_select();
        test_r0_and_nowrite();
        test_bypass();
        test_wrap();
        test_reset_midcycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
